// File: rtl/dmem_dump_if.sv
// Processor data-memory port plus the dump stream channel, bundled between
// the processor/bench side (master) and the memory responder (slave).
interface dmem_dump_if #(
    parameter int N  = 64,
    parameter int AW = 6
);
    logic          DM_writeEnable;
    logic [N-1:0]  DM_addr;
    logic [N-1:0]  DM_writeData;
    logic [N-1:0]  DM_readData;
    logic          dump;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_index;
    logic [N-1:0]  dump_data;
    logic          dump_done;

    modport master (
        output DM_writeEnable, DM_addr, DM_writeData, dump, dump_ready,
        input  DM_readData, dump_valid, dump_index, dump_data, dump_done
    );

    modport slave (
        input  DM_writeEnable, DM_addr, DM_writeData, dump, dump_ready,
        output DM_readData, dump_valid, dump_index, dump_data, dump_done
    );
endinterface

// File: rtl/dmem_dump_responder.sv
// Word-addressed data memory with combinational loads, single-cycle stores and
// a one-shot, back-pressurable sweep that streams every word on a dump request.
module dmem_dump_responder #(
    parameter int N     = 64,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input logic         CLOCK_50,
    input logic         reset,
    dmem_dump_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] idx;
    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          dump_valid;
    logic          dump_done;
    logic [AW-1:0] dump_index;
    logic [N-1:0]  dump_data;
    logic          unused_addr_bits;

    // Byte address to word index; the low byte-offset and high bits alias away.
    assign idx              = bus.DM_addr[AW+2:3];
    assign unused_addr_bits = ^{bus.DM_addr[N-1:AW+3], bus.DM_addr[2:0]};

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.DM_writeEnable) begin
            mem[idx] <= bus.DM_writeData;
        end
    end

    assign bus.DM_readData = mem[idx];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        dump_index = '0;
        dump_data  = '0;
        case (state_q)
            IDLE: begin
                if (bus.dump) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            SWEEP: begin
                dump_valid = 1'b1;
                dump_index = ptr_q;
                dump_data  = mem[ptr_q];
                // The last index retires to DONE instead of wrapping.
                if (bus.dump_ready) begin
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        state_d = DONE;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end
            DONE: begin
                dump_done = 1'b1;
                if (!bus.dump) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.dump_valid = dump_valid;
    assign bus.dump_done  = dump_done;
    assign bus.dump_index = dump_index;
    assign bus.dump_data  = dump_data;

endmodule

// File: tb/tb_dmem_dump_responder.sv
// Directed bench for dmem_dump_responder: stores, loads, aliasing, reset and
// the dump sweep with and without backpressure.
module tb_dmem_dump_responder;

    localparam int N     = 64;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic CLOCK_50;
    logic reset;
    int   errors;
    int   checks;

    dmem_dump_if #(.N(N), .AW(AW)) bus ();

    dmem_dump_responder #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus.slave)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Tasks start and end 2 time units after a rising edge.
    task automatic do_write(input logic [N-1:0] addr, input logic [N-1:0] data);
        bus.DM_writeEnable = 1'b1;
        bus.DM_addr        = addr;
        bus.DM_writeData   = data;
        @(posedge CLOCK_50);
        #1;
        bus.DM_writeEnable = 1'b0;
        #1;
    endtask

    task automatic fill_mem(input int mode);
        for (int i = 0; i < DEPTH; i++) begin
            if (mode == 0) do_write(N'(i * 8), N'(i + 1));
            else           do_write(N'(i * 8), N'(i * 3));
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.dump_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid actual=%0b required=0", bus.dump_valid);
        end
        checks++;
        if (bus.dump_done !== 1'b0) begin
            errors++; $display("FAIL reset_done actual=%0b required=0", bus.dump_done);
        end
        checks++;
        if (bus.dump_index !== '0 || bus.dump_data !== '0) begin
            errors++; $display("FAIL reset_index_data actual=%0d/%0h required=0/0", bus.dump_index, bus.dump_data);
        end
        bus.DM_addr = 64'h28;
        #1;
        checks++;
        if (bus.DM_readData !== '0) begin
            errors++; $display("FAIL reset_mem actual=%0h required=0", bus.DM_readData);
        end
        #1;
    endtask

    task automatic test_store_load();
        do_write(64'h10, 64'hDEADBEEF_00000001);
        do_write(64'h18, 64'h55);
        bus.DM_addr = 64'h10; #1;
        checks++;
        if (bus.DM_readData !== 64'hDEADBEEF_00000001) begin
            errors++; $display("FAIL load_0x10 actual=%0h required=deadbeef00000001", bus.DM_readData);
        end
        bus.DM_addr = 64'h18; #1;
        checks++;
        if (bus.DM_readData !== 64'h55) begin
            errors++; $display("FAIL load_0x18 actual=%0h required=55", bus.DM_readData);
        end
        bus.DM_addr = 64'h20; #1;
        checks++;
        if (bus.DM_readData !== 64'h0) begin
            errors++; $display("FAIL load_0x20 actual=%0h required=0", bus.DM_readData);
        end
        // Load during a store cycle shows the old word, the new one after the edge.
        bus.DM_writeEnable = 1'b1;
        bus.DM_addr        = 64'h10;
        bus.DM_writeData   = 64'h1234;
        #1;
        checks++;
        if (bus.DM_readData !== 64'hDEADBEEF_00000001) begin
            errors++; $display("FAIL load_during_store actual=%0h required=deadbeef00000001", bus.DM_readData);
        end
        @(posedge CLOCK_50);
        #1;
        bus.DM_writeEnable = 1'b0;
        #1;
        checks++;
        if (bus.DM_readData !== 64'h1234) begin
            errors++; $display("FAIL load_after_store actual=%0h required=1234", bus.DM_readData);
        end
    endtask

    task automatic test_alias();
        do_write(64'h13, 64'hA5);
        bus.DM_addr = 64'h10; #1;
        checks++;
        if (bus.DM_readData !== 64'hA5) begin
            errors++; $display("FAIL alias_low_bits actual=%0h required=a5", bus.DM_readData);
        end
        do_write(64'h208, 64'h77);
        bus.DM_addr = 64'h08; #1;
        checks++;
        if (bus.DM_readData !== 64'h77) begin
            errors++; $display("FAIL alias_wrap actual=%0h required=77", bus.DM_readData);
        end
        #1;
    endtask

    task automatic test_reset_clear();
        int bad;
        fill_mem(0);
        bus.DM_addr = 64'h1F8; #1;
        checks++;
        if (bus.DM_readData !== 64'd64) begin
            errors++; $display("FAIL fill_last actual=%0h required=40", bus.DM_readData);
        end
        reset = 1'b1;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        #1;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            bus.DM_addr = N'(i * 8);
            #1;
            if (bus.DM_readData !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL reset_clear_mem actual=%0d nonzero words required=0", bad);
        end
        checks++;
        if (bus.dump_valid !== 1'b0 || bus.dump_done !== 1'b0 || bus.dump_index !== '0 || bus.dump_data !== '0) begin
            errors++; $display("FAIL reset_clear_dump actual=%0b%0b/%0d/%0h required=00/0/0",
                               bus.dump_valid, bus.dump_done, bus.dump_index, bus.dump_data);
        end
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic test_stream();
        fill_mem(1);
        bus.dump_ready = 1'b1;
        bus.dump       = 1'b1;
        #1;
        checks++;
        if (bus.dump_valid !== 1'b0) begin
            errors++; $display("FAIL stream_latency actual=%0b required=0", bus.dump_valid);
        end
        @(posedge CLOCK_50);
        #2;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (bus.dump_valid !== 1'b1 || bus.dump_index !== AW'(i) || bus.dump_data !== N'(i * 3)) begin
                errors++; $display("FAIL stream_beat%0d actual=v%0b i%0d d%0d required=v1 i%0d d%0d",
                                   i, bus.dump_valid, bus.dump_index, bus.dump_data, i, i * 3);
            end
            @(posedge CLOCK_50);
            #2;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (bus.dump_done !== 1'b1 || bus.dump_valid !== 1'b0) begin
                errors++; $display("FAIL stream_done_hold%0d actual=done%0b valid%0b required=done1 valid0",
                                   k, bus.dump_done, bus.dump_valid);
            end
            @(posedge CLOCK_50);
            #2;
        end
        bus.dump = 1'b0;
        @(posedge CLOCK_50);
        #2;
        checks++;
        if (bus.dump_done !== 1'b0 || bus.dump_valid !== 1'b0) begin
            errors++; $display("FAIL stream_idle actual=done%0b valid%0b required=done0 valid0",
                               bus.dump_done, bus.dump_valid);
        end
    endtask

    task automatic test_backpressure();
        int  exp_idx;
        int  bad;
        logic saw_done;
        exp_idx  = 0;
        bad      = 0;
        saw_done = 1'b0;
        bus.dump = 1'b1;
        for (int c = 0; c < 300; c++) begin
            bus.dump_ready = ((c % 3) == 0);
            if (c == 3) bus.dump = 1'b0;
            #1;
            if (bus.dump_done === 1'b1) begin
                saw_done = 1'b1;
                break;
            end
            if (bus.dump_valid === 1'b1) begin
                if (bus.dump_index !== AW'(exp_idx) || bus.dump_data !== N'(exp_idx * 3)) begin
                    bad++;
                    $display("FAIL bp_beat actual=i%0d d%0d required=i%0d d%0d",
                             bus.dump_index, bus.dump_data, exp_idx, exp_idx * 3);
                end
                if (bus.dump_ready) exp_idx++;
            end
            @(posedge CLOCK_50);
            #1;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL bp_data actual=%0d bad beats required=0", bad);
        end
        checks++;
        if (exp_idx != DEPTH) begin
            errors++; $display("FAIL bp_count actual=%0d required=%0d", exp_idx, DEPTH);
        end
        checks++;
        if (!saw_done) begin
            errors++; $display("FAIL bp_done actual=0 required=1");
        end
        bus.dump_ready = 1'b1;
        @(posedge CLOCK_50);
        #1;
        checks++;
        if (bus.dump_done !== 1'b0 || bus.dump_valid !== 1'b0) begin
            errors++; $display("FAIL bp_idle actual=done%0b valid%0b required=done0 valid0",
                               bus.dump_done, bus.dump_valid);
        end
        #1;
    endtask

    task automatic test_reset_mid_dump();
        int bad;
        fill_mem(0);
        bus.dump_ready = 1'b1;
        bus.dump       = 1'b1;
        @(posedge CLOCK_50);
        #2;
        for (int i = 0; i <= 10; i++) begin
            checks++;
            if (bus.dump_valid !== 1'b1 || bus.dump_index !== AW'(i) || bus.dump_data !== N'(i + 1)) begin
                errors++; $display("FAIL mid_beat%0d actual=v%0b i%0d d%0d required=v1 i%0d d%0d",
                                   i, bus.dump_valid, bus.dump_index, bus.dump_data, i, i + 1);
            end
            @(posedge CLOCK_50);
            #2;
        end
        reset    = 1'b1;
        bus.dump = 1'b0;
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.dump_valid !== 1'b0 || bus.dump_done !== 1'b0) begin
            errors++; $display("FAIL mid_abort actual=valid%0b done%0b required=valid0 done0",
                               bus.dump_valid, bus.dump_done);
        end
        bus.DM_addr = 64'h50; #1;
        checks++;
        if (bus.DM_readData !== '0) begin
            errors++; $display("FAIL mid_mem_clear actual=%0h required=0", bus.DM_readData);
        end
        #1;
        bus.dump = 1'b1;
        @(posedge CLOCK_50);
        #2;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.dump_valid !== 1'b1 || bus.dump_index !== AW'(i) || bus.dump_data !== '0) bad++;
            @(posedge CLOCK_50);
            #2;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL mid_resweep actual=%0d bad beats required=0", bad);
        end
        checks++;
        if (bus.dump_done !== 1'b1) begin
            errors++; $display("FAIL mid_resweep_done actual=%0b required=1", bus.dump_done);
        end
        bus.dump = 1'b0;
        @(posedge CLOCK_50);
        #2;
    endtask

    initial begin
        errors             = 0;
        checks             = 0;
        reset              = 1'b1;
        bus.DM_writeEnable = 1'b0;
        bus.DM_addr        = '0;
        bus.DM_writeData   = '0;
        bus.dump           = 1'b0;
        bus.dump_ready     = 1'b0;
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        reset = 1'b0;
        #1;
        test_reset();
        test_store_load();
        test_alias();
        test_reset_clear();
        test_stream();
        test_backpressure();
        test_reset_mid_dump();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_dump_responder.md
Name: dmem_dump_responder

Overview:
- Data-memory responder on the far end of the processor's DM_* write interface.
- Accepts single-cycle stores, serves combinational loads, and answers the processor's `dump` request.
- On a dump it streams every memory word out over a valid/ready channel for bench checking.
- Sits beside processor_arm in the top level; replaces ad-hoc memory dumping with a deterministic, back-pressurable stream.

Parameters:
- N, 64, data word width in bits.
- DEPTH, 64, number of N-bit words; power of two.
- AW, $clog2(DEPTH), word-index width.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- DM_writeEnable  input  1  store strobe from processor.
- DM_addr  input  N  byte address from processor.
- DM_writeData  input  N  store data.
- DM_readData  output  N  load data, combinational from DM_addr.
- dump  input  1  dump request level from processor/bench.
- dump_valid  output  1  dump beat valid.
- dump_ready  input  1  sink accepts beat.
- dump_index  output  AW  word index of current beat.
- dump_data  output  N  word contents of current beat.
- dump_done  output  1  full sweep finished.

Behaviour:
- Addressing:
  - word index idx = DM_addr[AW+2:3].
  - DM_addr[2:0] and bits above AW+2 are ignored, so addresses alias modulo DEPTH*8.
- Store: on the rising edge with DM_writeEnable=1, mem[idx] <= DM_writeData. There is no byte masking.
- Load: DM_readData = mem[idx] combinationally, with zero-cycle latency. It shows the pre-write value during the store cycle.
- Reset: all words clear to 0 on the edge where reset=1. State goes to IDLE; dump_valid=0, dump_done=0, dump_index=0, dump_data=0.
  - Reset overrides a simultaneous store.
  - Reset mid-dump aborts the sweep immediately.
- FSM states:
  - IDLE: dump_valid=0, dump_done=0, dump_data=0. If dump=1, go to SWEEP with ptr=0 on the next edge.
  - SWEEP:
    - dump_valid=1, dump_index=ptr, dump_data=mem[ptr] (combinational).
    - On an edge with dump_valid && dump_ready: if ptr==DEPTH-1 go to DONE, else ptr <= ptr+1.
    - Without ready, ptr, dump_index and dump_data hold. dump_data may change only if a store hits mem[ptr].
    - dump deasserting during SWEEP does not abort.
  - DONE: dump_valid=0, dump_done=1. Stay while dump=1. When dump=0, go to IDLE on the next edge.
- A level-high dump therefore produces exactly one sweep; a new sweep needs dump low for at least 1 cycle.
- Latency: first beat is valid 1 cycle after dump is sampled high. With ready tied high, the sweep takes DEPTH cycles and dump_done rises on the cycle after the last handshake.
- Stores during SWEEP are still performed:
  - Words not yet emitted are dumped with their new value.
  - A store to mem[ptr] in the handshake cycle does not affect the accepted beat (old value is transferred).
- ptr never wraps. Beats are issued once per index, in ascending order, with no gaps or duplicates.

Test Plan:
- Store/load: store 0xDEADBEEF_00000001 at addr 0x10, then 0x55 at addr 0x18; DM_readData at 0x10 = 0xDEADBEEF_00000001, at 0x18 = 0x55, at 0x20 = 0.
- Aliasing: store 0xA5 at addr 0x13 -> read at 0x10 returns 0xA5. Store 0x77 at 0x208 (DEPTH=64) -> read at 0x08 returns 0x77.
- Reset clears: fill all 64 words with idx+1, pulse reset 1 cycle -> every load returns 0 and all dump outputs are 0.
- Streaming dump: words = idx*3, dump held high, dump_ready=1 -> 64 beats on consecutive cycles with dump_index 0..63 and dump_data 0..189. dump_done=1 the next cycle and stays high while dump=1; no second sweep follows.
- Backpressure: dump_ready toggles 1,0,0,1,… -> beats stall with dump_index/dump_data stable; all 64 beats still arrive in order with correct data.
- Reset mid-dump: assert reset after beat 10 -> next cycle dump_valid=0, dump_done=0, memory is zero. A new dump streams 64 zero words from index 0.
